// File: rtl/multi_channel_timer.sv
// Multi-channel down-counting timer.
// A shared prescaler divides clk down to a base tick. Each channel counts base
// ticks down from its own programmable period, in one-shot or periodic mode,
// and reports a timeout pulse, a sticky expired flag and the remaining count.
module multi_channel_timer #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 1,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    ld_valid,
    input  logic [CH_W-1:0]         ld_ch,
    input  logic [CNT_W-1:0]        ld_period,
    input  logic                    ld_periodic,
    output logic                    ld_err,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       clr,
    output logic                    tick_o,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam int               PRESCALE = CLK_FREQ_HZ / TICK_HZ;
    localparam int               PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             tick;
    logic             tick_q;
    logic             ld_err_q;
    logic             ld_err_d;
    logic             ld_range_ok;
    logic             ld_accept;

    // When NUM_CH fills the index field every encodable channel exists,
    // so the range test collapses to a constant.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_full_range
            assign ld_range_ok = 1'b1;
        end else begin : g_part_range
            assign ld_range_ok = (32'(ld_ch) < NUM_CH);
        end
    endgenerate

    // Prescaler next state, base tick and load validation.
    always_comb begin
        tick      = enable && (pre_cnt_q == PRE_LAST);
        pre_cnt_d = pre_cnt_q;
        if (enable) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
        ld_accept = ld_valid && (ld_period != '0) && ld_range_ok;
        ld_err_d  = ld_valid && ((ld_period == '0) || !ld_range_ok);
    end

    // Free-running prescaler plus registered tick and load-error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick;
            ld_err_q  <= ld_err_d;
        end
    end

    assign tick_o = tick_q;
    assign ld_err = ld_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t        state_q;
            ch_state_t        state_d;
            logic [CNT_W-1:0] rem_q;
            logic [CNT_W-1:0] rem_d;
            logic [CNT_W-1:0] period_q;
            logic [CNT_W-1:0] period_d;
            logic             periodic_q;
            logic             periodic_d;
            logic             timeout_q;
            logic             timeout_d;
            logic             expired_q;
            logic             expired_d;
            logic             ld_hit;

            assign ld_hit = ld_accept && (ld_ch == CH_W'(gi));

            // Channel next state: stop beats start beats tick. Start samples the
            // period register before any same-cycle load lands.
            always_comb begin
                state_d    = state_q;
                rem_d      = rem_q;
                timeout_d  = 1'b0;
                expired_d  = expired_q;
                period_d   = ld_hit ? ld_period : period_q;
                periodic_d = ld_hit ? ld_periodic : periodic_q;

                if (clr[gi]) begin
                    expired_d = 1'b0;
                end

                if (stop[gi]) begin
                    state_d = CH_IDLE;
                    rem_d   = '0;
                end else if (start[gi]) begin
                    state_d = CH_RUN;
                    rem_d   = period_q;
                end else if ((state_q == CH_RUN) && tick) begin
                    if (rem_q > ONE) begin
                        rem_d = rem_q - ONE;
                    end else if (periodic_q) begin
                        timeout_d = 1'b1;
                        rem_d     = period_q;
                    end else begin
                        timeout_d = 1'b1;
                        expired_d = 1'b1;
                        state_d   = CH_IDLE;
                        rem_d     = '0;
                    end
                end
            end

            // Channel state, counters and registered flags.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q    <= CH_IDLE;
                    rem_q      <= '0;
                    period_q   <= DEF_P;
                    periodic_q <= 1'b0;
                    timeout_q  <= 1'b0;
                    expired_q  <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    rem_q      <= rem_d;
                    period_q   <= period_d;
                    periodic_q <= periodic_d;
                    timeout_q  <= timeout_d;
                    expired_q  <= expired_d;
                end
            end

            assign timeout[gi]                   = timeout_q;
            assign busy[gi]                      = (state_q == CH_RUN);
            assign expired[gi]                   = expired_q;
            assign remaining[gi*CNT_W +: CNT_W]  = rem_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer with PRESCALE=10, four 8-bit channels.
// A second, three-channel instance exercises the out-of-range channel index.
module tb_multi_channel_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        ld_valid = 1'b0;
    logic [1:0]  ld_ch = 2'd0;
    logic [7:0]  ld_period = 8'd0;
    logic        ld_periodic = 1'b0;
    logic [3:0]  start = 4'd0;
    logic [3:0]  stop = 4'd0;
    logic [3:0]  clr = 4'd0;

    logic        ld_err, tick_o;
    logic [3:0]  timeout, busy, expired;
    logic [31:0] remaining;

    logic        ld_err3, tick_o3;
    logic [2:0]  timeout3, busy3, expired3;
    logic [23:0] remaining3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_channel_timer #(
        .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_CH(4), .CNT_W(8), .DEFAULT_PERIOD(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .ld_valid(ld_valid), .ld_ch(ld_ch),
        .ld_period(ld_period), .ld_periodic(ld_periodic), .ld_err(ld_err),
        .start(start), .stop(stop), .clr(clr), .tick_o(tick_o), .timeout(timeout),
        .busy(busy), .expired(expired), .remaining(remaining)
    );

    multi_channel_timer #(
        .CLK_FREQ_HZ(10), .TICK_HZ(1), .NUM_CH(3), .CNT_W(8), .DEFAULT_PERIOD(1)
    ) u_dut3 (
        .clk(clk), .rst(rst), .enable(enable), .ld_valid(ld_valid), .ld_ch(ld_ch),
        .ld_period(ld_period), .ld_periodic(ld_periodic), .ld_err(ld_err3),
        .start(start[2:0]), .stop(stop[2:0]), .clr(clr[2:0]), .tick_o(tick_o3),
        .timeout(timeout3), .busy(busy3), .expired(expired3), .remaining(remaining3)
    );

    typedef struct packed {
        logic        ld_valid;
        logic [1:0]  ld_ch;
        logic [7:0]  ld_period;
        logic        ld_periodic;
        logic [3:0]  start;
        logic [3:0]  stop;
        logic [3:0]  clr;
        logic        e_ld_err;
        logic [3:0]  e_busy;
        logic [3:0]  e_expired;
        logic [31:0] e_rem;
    } vec_t;

    vec_t vecs[14];

    // One clock edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] p, input logic per);
        ld_valid = 1'b1; ld_ch = ch; ld_period = p; ld_periodic = per;
        cyc();
        ld_valid = 1'b0;
    endtask

    function automatic logic [7:0] rem_of(input int ch);
        return 8'(remaining >> (ch * 8));
    endfunction

    initial begin
        int cnt, first, tick_at, found;
        int tt[5];

        // ld_valid ld_ch period per start stop clr | ld_err busy expired remaining
        vecs[0]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 32'h0000_0001};
        vecs[1]  = '{1'b1, 2'd0, 8'd3, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 32'h0000_0001};
        vecs[2]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 32'h0000_0003};
        vecs[3]  = '{1'b1, 2'd1, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 32'h0000_0003};
        vecs[4]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 32'h0000_0003};
        vecs[5]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0011, 4'b0000, 32'h0000_0103};
        vecs[6]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0011, 4'b0000, 32'h0000_0103};
        vecs[7]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000};
        vecs[8]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000};
        vecs[9]  = '{1'b1, 2'd2, 8'd7, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 32'h0007_0000};
        vecs[11] = '{1'b1, 2'd2, 8'd9, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 32'h0007_0000};
        vecs[12] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 32'h0009_0000};
        vecs[13] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_tick_o", 32'(tick_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        check("rst_remaining", remaining, 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        rst = 1'b1;

        // Control-path table with the prescaler frozen
        for (int i = 0; i < 14; i++) begin
            ld_valid = vecs[i].ld_valid; ld_ch = vecs[i].ld_ch;
            ld_period = vecs[i].ld_period; ld_periodic = vecs[i].ld_periodic;
            start = vecs[i].start; stop = vecs[i].stop; clr = vecs[i].clr;
            cyc();
            ld_valid = 1'b0; start = '0; stop = '0; clr = '0;
            check($sformatf("vec%0d_ld_err", i), 32'(ld_err), 32'(vecs[i].e_ld_err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].e_expired));
            check($sformatf("vec%0d_remaining", i), remaining, vecs[i].e_rem);
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
        end

        // Case 1: free run, 10 tick_o pulses in 100 cycles, first after 10 edges
        enable = 1'b1;
        cnt = 0; first = -1;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (tick_o) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("freerun_pulses", 32'(cnt), 32'd10);
        check("freerun_first", 32'(first), 32'd10);

        // Case 1b: five disabled cycles stretch the gap to 15
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (tick_o) begin first = k; break; end
            if (k == 3) enable = 1'b0;
            if (k == 8) enable = 1'b1;
        end
        check("gap_with_disable", 32'(first), 32'd15);

        // Case 2: one-shot ch0, period 3
        start = 4'b0001; cyc(); start = '0;
        cnt = 0; first = -1; tick_at = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (timeout[0]) begin
                cnt++;
                if (first < 0) begin first = k; tick_at = int'(tick_o); end
            end
        end
        check_rng("oneshot_latency", first, 21, 30);
        check("oneshot_count", 32'(cnt), 32'd1);
        check("timeout_aligned_tick_o", 32'(tick_at), 32'd1);
        check("oneshot_expired", 32'(expired[0]), 32'd1);
        check("oneshot_busy", 32'(busy[0]), 32'd0);
        clr = 4'b0001; cyc(); clr = '0;
        check("clr_expired", 32'(expired[0]), 32'd0);

        // Case 3: periodic ch1, period 2
        load(2'd1, 8'd2, 1'b1);
        start = 4'b0010; cyc(); start = '0;
        cnt = 0;
        for (int k = 1; k <= 110; k++) begin
            cyc();
            if (timeout[1]) begin
                if (cnt < 5) tt[cnt] = k;
                cnt++;
            end
        end
        check("periodic_count", 32'(cnt), 32'd5);
        check_rng("periodic_first", tt[0], 11, 20);
        for (int j = 1; j < 5; j++) begin
            check($sformatf("periodic_gap%0d", j), 32'(tt[j] - tt[j-1]), 32'd20);
        end
        check("periodic_busy", 32'(busy[1]), 32'd1);
        stop = 4'b0010; cyc(); stop = '0;
        check("periodic_stop_busy", 32'(busy[1]), 32'd0);
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (timeout[1]) cnt++;
        end
        check("periodic_stopped_silent", 32'(cnt), 32'd0);

        // Case 4: restart on the final tick; clr loses to expire
        load(2'd2, 8'd1, 1'b0);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (tick_o) begin found = 1; break; end
        end
        check("sync_tick_seen", 32'(found), 32'd1);
        start = 4'b1100; cyc(); start = '0;
        check("prio_rem2", 32'(rem_of(2)), 32'd1);
        check("prio_rem3", 32'(rem_of(3)), 32'd1);
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (timeout[3:2] != 2'b00) cnt++;
        end
        check("prio_no_early_timeout", 32'(cnt), 32'd0);
        start = 4'b0100; clr = 4'b1000; cyc(); start = '0; clr = '0;
        check("prio_on_tick_edge", 32'(tick_o), 32'd1);
        check("restart_no_timeout", 32'(timeout[2]), 32'd0);
        check("restart_busy", 32'(busy[2]), 32'd1);
        check("restart_rem", 32'(rem_of(2)), 32'd1);
        check("ch3_timeout", 32'(timeout[3]), 32'd1);
        check("set_beats_clr", 32'(expired[3]), 32'd1);
        check("ch3_idle", 32'(busy[3]), 32'd0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (timeout[2] && first < 0) first = k;
        end
        check("restart_timeout_edge", 32'(first), 32'd10);
        check("restart_expired", 32'(expired[2]), 32'd1);
        clr = 4'b1111; cyc(); clr = '0;
        check("clr_all", 32'(expired), 32'd0);

        // Case 5: load errors and the widest period
        load(2'd3, 8'd5, 1'b0);
        check("ld_ch3_ok_4ch", 32'(ld_err), 32'd0);
        check("ld_ch3_err_3ch", 32'(ld_err3), 32'd1);
        load(2'd0, 8'd0, 1'b0);
        check("ld_zero_err", 32'(ld_err), 32'd1);
        cyc();
        check("ld_err_one_cycle", 32'(ld_err), 32'd0);
        start = 4'b0001; cyc(); start = '0;
        check("ld_zero_period_kept", 32'(rem_of(0)), 32'd3);
        stop = 4'b0001; cyc(); stop = '0;
        load(2'd0, 8'd255, 1'b0);
        start = 4'b0001; cyc(); start = '0;
        first = -1;
        for (int k = 1; k <= 2600; k++) begin
            cyc();
            if (timeout[0]) begin first = k; break; end
        end
        check_rng("p255_latency", first, 2541, 2550);

        // Case 6: asynchronous reset mid-count
        start = 4'b0010; cyc(); start = '0;
        for (int k = 0; k < 5; k++) cyc();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_remaining", remaining, 32'd0);
        check("arst_tick_o", 32'(tick_o), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0; first = -1;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (timeout != 4'b0000) cnt++;
            if (tick_o && first < 0) first = k;
        end
        check("post_rst_no_timeout", 32'(cnt), 32'd0);
        check("post_rst_first_tick", 32'(first), 32'd10);
        enable = 1'b0;
        start = 4'b1111; cyc(); start = '0;
        check("post_rst_default_period", remaining, 32'h0101_0101);
        check("post_rst_busy", 32'(busy), 32'hF);
        enable = 1'b1;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (timeout != 4'b0000) begin found = int'(timeout); break; end
        end
        check("post_rst_oneshot_timeout", 32'(found), 32'hF);
        check("post_rst_oneshot_expired", 32'(expired), 32'hF);
        check("post_rst_oneshot_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
